microcode_sequencer: RTL

//  Multi-step microcode engine replacing the single-word opcode lookup. Holds a bootstrappable

---
 rtl/microcode_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: bootstrappable multi-step microcode engine driving registered plane strobes
// Ports:
//   CLK, RST                         clock, synchronous active-high reset
//   OPCODE, OPCODE_VALID/READY       opcode handshake from the instruction register
//   N_IN, N_OUT                      one-hot active-low plane strobes (bit k = select k+1)
//   ALU_OP, REG_SEL, REG_SRC         decoded control fields
//   HALTED, FAULT                    halt status and sticky error flag
//   BOOTSTRAP_ADDR/DATA/N_WE         byte-wide control store loader
//   N_BOOTED                         low once bootstrap is complete
module microcode_sequencer #(
    parameter int OPCODE_W = 6,
    parameter int STEP_W   = 3,
    parameter int PLANE_W  = 3,
    parameter int WORD_W   = 32
) (
    input  logic                                               CLK,
    input  logic                                               RST,
    input  logic [OPCODE_W-1:0]                                OPCODE,
    input  logic                                               OPCODE_VALID,
    output logic                                               OPCODE_READY,
    output logic [2**PLANE_W-2:0]                              N_IN,
    output logic [2**PLANE_W-2:0]                              N_OUT,
    output logic [PLANE_W-1:0]                                 ALU_OP,
    output logic [1:0]                                         REG_SEL,
    output logic [4:0]                                         REG_SRC,
    output logic                                               HALTED,
    output logic                                               FAULT,
    input  logic [OPCODE_W+STEP_W+$clog2(WORD_W/8)-1:0]        BOOTSTRAP_ADDR,
    input  logic [7:0]                                         BOOTSTRAP_DATA,
    input  logic                                               BOOTSTRAP_N_WE,
    input  logic                                               N_BOOTED
);
    localparam int NB   = WORD_W / 8;
    localparam int BA_W = $clog2(NB);
    localparam int AW   = OPCODE_W + STEP_W + BA_W;
    localparam int N    = 2**PLANE_W - 1;
    localparam int F    = WORD_W - 1 - 3*PLANE_W;

    typedef enum logic [1:0] {S_BOOT, S_IDLE, S_EXEC, S_HALT} state_t;

    state_t state, state_d;
    logic [7:0] store [2**AW];
    logic [OPCODE_W-1:0] op, op_d;
    logic [STEP_W-1:0] step, step_d;
    logic [WORD_W-1:0] word;
    logic [PLANE_W-1:0] in_sel, out_sel;
    logic [N-1:0] in_hot, out_hot, n_in_d, n_out_d;
    logic [PLANE_W-1:0] alu_d;
    logic [1:0] rs_d;
    logic [4:0] src_d;
    logic ready_d, halted_d, fault_set, wr, conflict;

    assign wr = state == S_BOOT && N_BOOTED && !BOOTSTRAP_N_WE;

    // Store has no reset so its contents survive RST.
    always_ff @(posedge CLK)
        if (wr) store[BOOTSTRAP_ADDR] <= BOOTSTRAP_DATA;

    // Byte 0 of each word is the most significant byte.
    always_comb begin
        word = '0;
        for (int b = 0; b < NB; b++)
            word[WORD_W-1-8*b -: 8] = store[{op, step, BA_W'(b)}];
    end

    assign in_sel   = word[WORD_W-1 -: PLANE_W];
    assign out_sel  = word[WORD_W-1-PLANE_W -: PLANE_W];
    assign conflict = in_sel == out_sel && in_sel != '0;

    always_comb begin
        in_hot  = '0;
        out_hot = '0;
        for (int k = 0; k < N; k++) begin
            in_hot[k]  = in_sel == PLANE_W'(k + 1);
            out_hot[k] = out_sel == PLANE_W'(k + 1);
        end
    end

    always_comb begin
        state_d   = state;
        op_d      = op;
        step_d    = step;
        n_in_d    = '1;
        n_out_d   = '1;
        alu_d     = '0;
        rs_d      = '0;
        src_d     = '0;
        halted_d  = HALTED;
        fault_set = !BOOTSTRAP_N_WE && !wr;
        case (state)
            S_BOOT: state_d = N_BOOTED ? S_BOOT : S_IDLE;
            S_IDLE:
                if (OPCODE_VALID && OPCODE_READY) begin
                    op_d    = OPCODE;
                    step_d  = '0;
                    state_d = S_EXEC;
                end
            S_EXEC: begin
                n_in_d    = conflict ? '1 : ~in_hot;
                n_out_d   = conflict ? '1 : ~out_hot;
                alu_d     = word[WORD_W-1-2*PLANE_W -: PLANE_W];
                rs_d      = word[F -: 2] == 2'd3 ? 2'd2 : word[F -: 2];
                src_d     = word[F-2 -: 5];
                fault_set = fault_set | conflict | (word[F -: 2] == 2'd3);
                step_d    = step + 1'b1;
                // HALT takes priority over END; running off the last step without END is an error.
                if (word[F-8]) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (word[F-7]) begin
                    state_d = S_IDLE;
                end else if (&step) begin
                    state_d   = S_IDLE;
                    fault_set = 1'b1;
                end
            end
            default: ;
        endcase
        // READY rises one cycle after returning to IDLE so the last word gets its own cycle.
        ready_d = state == S_IDLE && state_d == S_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= N_BOOTED ? S_BOOT : S_IDLE;
            op           <= '0;
            step         <= '0;
            N_IN         <= '1;
            N_OUT        <= '1;
            ALU_OP       <= '0;
            REG_SEL      <= '0;
            REG_SRC      <= '0;
            OPCODE_READY <= 1'b0;
            HALTED       <= 1'b0;
            FAULT        <= 1'b0;
        end else begin
            state        <= state_d;
            op           <= op_d;
            step         <= step_d;
            N_IN         <= n_in_d;
            N_OUT        <= n_out_d;
            ALU_OP       <= alu_d;
            REG_SEL      <= rs_d;
            REG_SRC      <= src_d;
            OPCODE_READY <= ready_d;
            HALTED       <= halted_d;
            FAULT        <= FAULT | fault_set;
        end
    end
endmodule
